pipe_addsub: RTL and testbench

//  Parametrised, pipelined add/subtract unit: the multi-bit successor to the 4-bit ripple adder.

---
 rtl/pipe_addsub.sv | 125 ++++++++++++
 tb/tb_pipe_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: a WIDTH-bit operation is resolved STAGE_W bits per stage,
// with the inter-chunk carry registered between stages and a valid/ready handshake with global stall.
module pipe_addsub #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / STAGE_W;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % STAGE_W != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGE_W");
    end

    logic              en;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    logic [STAGES-1:0] src_v, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [STAGE_W:0]  chunk [STAGES];
    logic              msb_cin;

    assign en       = !vld_q[LAST] || out_ready;
    assign in_ready = en;

    // Stage 0 takes the operands directly; subtraction is A + ~B + ~borrow.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = in_a;
        src_b[0] = in_sub ? ~in_b : in_b;
        src_c[0] = in_sub ? ~in_c : in_c;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = cy_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            chunk[k] = {1'b0, src_a[k][k*STAGE_W +: STAGE_W]}
                     + {1'b0, src_b[k][k*STAGE_W +: STAGE_W]}
                     + {{STAGE_W{1'b0}}, src_c[k]};
        end
        // Carry into the MSB recovered from its sum bit: sum = a ^ b ^ cin.
        msb_cin = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ chunk[LAST][STAGE_W-1];
        if (en) begin
            vld_d = src_v;
            for (int k = 0; k < STAGES; k++) begin
                // The output stage only changes when a real op arrives, so bubbles leave out_* untouched.
                if (k != LAST || src_v[k]) begin
                    a_d[k] = src_a[k];
                    b_d[k] = src_b[k];
                    s_d[k] = src_s[k];
                    s_d[k][k*STAGE_W +: STAGE_W] = chunk[k][STAGE_W-1:0];
                    cy_d[k] = chunk[k][STAGE_W];
                end
            end
            if (src_v[LAST]) begin
                ovf_d = msb_cin ^ chunk[LAST][STAGE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_c     = cy_q[LAST];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=16, STAGE_W=4): table vectors, random bursts, stall and reset sequences,
// with a queue of expected results pushed on acceptance and popped when a result is consumed.
module tb_pipe_addsub;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_c;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_c;
    logic        out_ovf;

    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    int   run_len = 0;
    int   max_run = 0;
    res_t cur_exp;
    res_t mon_exp;
    res_t sb[$];

    pipe_addsub #(.WIDTH(16), .STAGE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_c(out_c), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Reference in plain integer arithmetic: unsigned for carry/borrow, signed for overflow.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
        res_t r;
        int   ua, ub, sa, sb2, u, s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb2 = $signed(b);
        if (sub) begin
            u = ua - ub - int'(c);
            s = sa - sb2 - int'(c);
            r.co = (u >= 0);
        end else begin
            u = ua + ub + int'(c);
            s = sa + sb2 + int'(c);
            r.co = (u > 65535);
        end
        r.sum = u[15:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                n_out++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result got sum=%h c=%b ovf=%b", out_sum, out_c, out_ovf);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_sum !== mon_exp.sum || out_c !== mon_exp.co || out_ovf !== mon_exp.ovf) begin
                        bad++;
                        $display("FAIL result got sum=%h c=%b ovf=%b exp sum=%h c=%b ovf=%b",
                                 out_sum, out_c, out_ovf, mon_exp.sum, mon_exp.co, mon_exp.ovf);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Presents one op and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub,
                        input res_t exp);
        int   tries;
        logic ok;
        in_a = a; in_b = b; in_c = c; in_sub = sub;
        cur_exp = exp;
        in_valid = 1'b1;
        tries = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            tries++;
        end while (!ok && tries < 50);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout got in_ready=0 exp in_ready=1");
        end
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int n;
        logic seen;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk(name, n, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    vec_t vecs[8];
    res_t r;
    int   n0;
    logic [15:0] ra, rb;
    logic rc, rs;

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0;
        cur_exp = '{16'h0, 1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            r = '{vecs[i].sum, vecs[i].co, vecs[i].ovf};
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, r);
            in_valid = 1'b0;
            wait_out($sformatf("latency_vec%0d", i), 4);
        end
        drain();

        // Back-to-back burst must come out as one unbroken run.
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        in_valid = 1'b0;
        drain();
        chk("burst_run", max_run, 8);

        // Stall with a full pipeline, then release.
        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        out_ready = 1'b0;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        in_a = ra; in_b = rb; in_c = rc; in_sub = rs;
        cur_exp = model(ra, rb, rc, rs);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            if (sb.size() != 0) begin
                chk("stall_out_sum", out_sum, sb[0].sum);
                chk("stall_out_c", out_c, sb[0].co);
                chk("stall_out_ovf", out_ovf, sb[0].ovf);
            end else begin
                chk("stall_sb_size", sb.size(), 4);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        in_valid = 1'b0;
        drain();
        chk("stall_delivered", n_out - n0, 8);

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        send(16'h1111, 16'h2222, 1'b1, 1'b0, model(16'h1111, 16'h2222, 1'b1, 1'b0));
        in_valid = 1'b0;
        wait_out("post_reset_latency", 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
